// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ram_arbiter_pkg;

   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 8;

   // Encodings for the RAM direction strobe (ram_n_rw)
   localparam logic RAM_RD = 1'b0;
   localparam logic RAM_WR = 1'b1;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WR         = 2'd1,
      RD_ISSUE   = 2'd2,
      RD_CAPTURE = 2'd3
   } arb_state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Request-side bundle for the two RAM requesters (port 0 fetch, port 1 data).
// Latency: n/a (wiring only).
// Backpressure: valid held by the master until ready; rvalid is a one-cycle strobe.
// Ports: reqN_valid/we/addr/wdata (master -> arbiter), reqN_ready/rvalid/rdata (arbiter -> master).
interface ram_arbiter_if
   import ram_arbiter_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic              req0_valid;
   logic              req0_we;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_wdata;
   logic              req0_ready;
   logic              req0_rvalid;
   logic [DATA_W-1:0] req0_rdata;

   logic              req1_valid;
   logic              req1_we;
   logic [ADDR_W-1:0] req1_addr;
   logic [DATA_W-1:0] req1_wdata;
   logic              req1_ready;
   logic              req1_rvalid;
   logic [DATA_W-1:0] req1_rdata;

   modport master (
      output req0_valid, req0_we, req0_addr, req0_wdata,
      input  req0_ready, req0_rvalid, req0_rdata,
      output req1_valid, req1_we, req1_addr, req1_wdata,
      input  req1_ready, req1_rvalid, req1_rdata
   );

   modport slave (
      input  req0_valid, req0_we, req0_addr, req0_wdata,
      output req0_ready, req0_rvalid, req0_rdata,
      input  req1_valid, req1_we, req1_addr, req1_wdata,
      output req1_ready, req1_rvalid, req1_rdata
   );
endinterface

// File: rtl/ram_arbiter_grant.sv
// Two-way grant selection: fixed priority (port 0 wins) or round-robin when RAM_ARBITER_RR_EN is defined.
// Latency: combinational grant; round-robin pointer updates on the accept edge.
// Backpressure: none; the caller masks the grant with its own accept condition.
// Ports: clk, n_rst, i_valid[1:0], i_accept (grant consumed this cycle), o_gnt[1:0] one-hot or zero.
module ram_arbiter_grant (
   input  logic       clk,
   input  logic       n_rst,
   input  logic [1:0] i_valid,
   input  logic       i_accept,
   output logic [1:0] o_gnt
);

`ifdef RAM_ARBITER_RR_EN
   // 1 = port 1 was granted last; resets to 1 so port 0 wins the first tie
   logic r_last;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_last <= 1'b1;
      end else if (i_accept) begin
         r_last <= o_gnt[1];
      end
   end

   always_comb begin
      o_gnt = 2'b00;
      if (&i_valid) begin
         o_gnt = r_last ? 2'b01 : 2'b10;
      end else if (i_valid[0]) begin
         o_gnt = 2'b01;
      end else if (i_valid[1]) begin
         o_gnt = 2'b10;
      end
   end
`else
   // Fixed priority keeps no state
   logic w_unused;
   assign w_unused = ^{clk, n_rst, i_accept};

   always_comb begin
      o_gnt = 2'b00;
      if (i_valid[0]) begin
         o_gnt = 2'b01;
      end else if (i_valid[1]) begin
         o_gnt = 2'b10;
      end
   end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer for a 256x8 single-port synchronous RAM (policy macro: RAM_ARBITER_RR_EN).
// Latency: write occupies 2 cycles (accept + WR); read returns rvalid/rdata 3 cycles after accept.
// Backpressure: reqN_ready only in IDLE, at most one per cycle; requester holds its request until ready.
// Ports: clk, n_rst, req (ram_arbiter_if.slave), busy, ram_n_cs/ram_n_rw/ram_n_oe, ram_addr, ram_data (tri-state).
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              n_rst,
   ram_arbiter_if.slave      req,
   output logic              busy,
   output logic              ram_n_cs,
   output logic              ram_n_rw,
   output logic              ram_n_oe,
   output logic [ADDR_W-1:0] ram_addr,
   inout  wire  [DATA_W-1:0] ram_data
);

   arb_state_t        r_state;
   logic              r_n_cs;
   logic              r_n_rw;
   logic              r_n_oe;
   logic              r_drive;
   logic              r_port;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata0;
   logic [DATA_W-1:0] r_rdata1;
   logic              r_rvalid0;
   logic              r_rvalid1;

   logic [1:0]        w_gnt;
   logic              w_idle;
   logic              w_accept;
   logic              w_we;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_wdata;

   assign w_idle   = (r_state == IDLE);
   assign w_accept = w_idle & (|w_gnt);

   // Request fields of whichever port holds the grant
   assign w_we    = w_gnt[1] ? req.req1_we    : req.req0_we;
   assign w_addr  = w_gnt[1] ? req.req1_addr  : req.req0_addr;
   assign w_wdata = w_gnt[1] ? req.req1_wdata : req.req0_wdata;

   ram_arbiter_grant u_grant (
      .clk      (clk),
      .n_rst    (n_rst),
      .i_valid  ({req.req1_valid, req.req0_valid}),
      .i_accept (w_accept),
      .o_gnt    (w_gnt)
   );

   assign req.req0_ready  = w_idle & w_gnt[0];
   assign req.req1_ready  = w_idle & w_gnt[1];
   assign req.req0_rvalid = r_rvalid0;
   assign req.req1_rvalid = r_rvalid1;
   assign req.req0_rdata  = r_rdata0;
   assign req.req1_rdata  = r_rdata1;

   assign busy     = ~w_idle;
   assign ram_n_cs = r_n_cs;
   assign ram_n_rw = r_n_rw;
   assign ram_n_oe = r_n_oe;
   assign ram_addr = r_addr;

   // Only WR drives the bus; the RAM drives only while n_oe=0 with n_rw=0
   assign ram_data = r_drive ? r_wdata : {DATA_W{1'bz}};

   // Strobes are registered alongside the next state so they change
   // on the same edge as the state and never see the req inputs directly.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state   <= IDLE;
         r_n_cs    <= 1'b1;
         r_n_rw    <= RAM_RD;
         r_n_oe    <= 1'b1;
         r_drive   <= 1'b0;
         r_port    <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_rdata0  <= '0;
         r_rdata1  <= '0;
         r_rvalid0 <= 1'b0;
         r_rvalid1 <= 1'b0;
      end else begin
         r_rvalid0 <= 1'b0;
         r_rvalid1 <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_port  <= w_gnt[1];
                  r_addr  <= w_addr;
                  r_wdata <= w_wdata;
                  r_n_cs  <= 1'b0;
                  r_n_oe  <= 1'b1;
                  if (w_we) begin
                     r_state <= WR;
                     r_n_rw  <= RAM_WR;
                     r_drive <= 1'b1;
                  end else begin
                     r_state <= RD_ISSUE;
                     r_n_rw  <= RAM_RD;
                  end
               end
            end
            WR: begin
               r_state <= IDLE;
               r_n_cs  <= 1'b1;
               r_n_rw  <= RAM_RD;
               r_drive <= 1'b0;
               r_addr  <= '0;
            end
            RD_ISSUE: begin
               r_state <= RD_CAPTURE;
               r_n_oe  <= 1'b0;
            end
            RD_CAPTURE: begin
               r_state <= IDLE;
               r_n_cs  <= 1'b1;
               r_n_oe  <= 1'b1;
               r_addr  <= '0;
               if (r_port) begin
                  r_rdata1  <= ram_data;
                  r_rvalid1 <= 1'b1;
               end else begin
                  r_rdata0  <= ram_data;
                  r_rvalid0 <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a behavioural 256x8 synchronous RAM.
// Latency: n/a (testbench).
// Backpressure: requesters hold valid until ready, as the block expects.
module tb_ram_arbiter;

   logic clk = 1'b0;
   logic n_rst;
   always #5 clk = ~clk;

   ram_arbiter_if #(.ADDR_W(8), .DATA_W(8)) rif ();

   logic       busy, ram_n_cs, ram_n_rw, ram_n_oe;
   logic [7:0] ram_addr;
   wire  [7:0] ram_data;

   ram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
      .clk      (clk),
      .n_rst    (n_rst),
      .req      (rif.slave),
      .busy     (busy),
      .ram_n_cs (ram_n_cs),
      .ram_n_rw (ram_n_rw),
      .ram_n_oe (ram_n_oe),
      .ram_addr (ram_addr),
      .ram_data (ram_data)
   );

   // Behavioural RAM: write on edge when selected for write, output register
   // loads on edge when selected for read, drives bus while n_oe low for read.
   logic [7:0] ram_mem [256];
   logic [7:0] ram_q;
   logic       pl_en;
   logic [7:0] pl_addr, pl_dat;

   always @(posedge clk) begin
      if (pl_en) ram_mem[pl_addr] <= pl_dat;
      else if (!ram_n_cs && ram_n_rw) ram_mem[ram_addr] <= ram_data;
      if (!ram_n_cs && !ram_n_rw) ram_q <= ram_mem[ram_addr];
   end
   assign ram_data = (!ram_n_cs && !ram_n_rw && !ram_n_oe) ? ram_q : 8'hzz;

   int rv0 = 0, rv1 = 0;
   always @(negedge clk) begin
      if (rif.req0_rvalid) rv0++;
      if (rif.req1_rvalid) rv1++;
   end

   logic [7:0] model_mem [256];
   int n_pass = 0, n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      else n_pass++;
   endtask

   task automatic fail_now(input string name);
      n_total++;
      $display("FAIL %s: no grant within cycle budget", name);
   endtask

   task automatic set_req(input int p, input logic v, input logic we, input logic [7:0] a, input logic [7:0] d);
      if (p == 0) begin
         rif.req0_valid = v; rif.req0_we = we; rif.req0_addr = a; rif.req0_wdata = d;
      end else begin
         rif.req1_valid = v; rif.req1_we = we; rif.req1_addr = a; rif.req1_wdata = d;
      end
   endtask

   function automatic logic get_ready(input int p);
      return (p == 0) ? rif.req0_ready : rif.req1_ready;
   endfunction
   function automatic logic get_rvalid(input int p);
      return (p == 0) ? rif.req0_rvalid : rif.req1_rvalid;
   endfunction
   function automatic logic [7:0] get_rdata(input int p);
      return (p == 0) ? rif.req0_rdata : rif.req1_rdata;
   endfunction

   task automatic do_reset();
      set_req(0, 0, 0, 0, 0);
      set_req(1, 0, 0, 0, 0);
      n_rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 n_rst = 1'b1;
   endtask

   typedef struct {
      int         port;
      logic       we;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp;
   } vec_t;

   // Starts and ends at posedge+1
   task automatic do_txn(input vec_t v);
      int o;
      o = 1 - v.port;
      set_req(v.port, 1'b1, v.we, v.addr, v.wdata);
      @(negedge clk);
      chk("acc_ready", get_ready(v.port), 1);
      chk("acc_other_ready", get_ready(o), 0);
      chk("acc_busy", busy, 0);
      @(posedge clk); #1;
      set_req(v.port, 1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge clk);
      chk("t1_ncs", ram_n_cs, 0);
      chk("t1_nrw", ram_n_rw, v.we);
      chk("t1_noe", ram_n_oe, 1);
      chk("t1_addr", ram_addr, v.addr);
      chk("t1_busy", busy, 1);
      chk("t1_ready", get_ready(v.port), 0);
      if (v.we) begin
         chk("t1_wdata", ram_data, v.wdata);
         model_mem[v.addr] = v.wdata;
         @(posedge clk); #1;
         @(negedge clk);
         chk("wr_ncs_released", ram_n_cs, 1);
         chk("wr_addr_idle", ram_addr, 0);
         chk("wr_mem", ram_mem[v.addr], v.wdata);
      end else begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("t2_ncs", ram_n_cs, 0);
         chk("t2_noe", ram_n_oe, 0);
         chk("t2_rvalid", get_rvalid(v.port), 0);
         @(posedge clk); #1;
         @(negedge clk);
         chk("t3_rvalid", get_rvalid(v.port), 1);
         chk("t3_other_rvalid", get_rvalid(o), 0);
         chk("t3_rdata", get_rdata(v.port), v.exp);
         chk("t3_busy", busy, 0);
         @(posedge clk); #1;
         @(negedge clk);
         chk("t4_rvalid_cleared", get_rvalid(v.port), 0);
         chk("t4_rdata_held", get_rdata(v.port), v.exp);
      end
      @(posedge clk); #1;
   endtask

   vec_t tbl[7];

   initial begin
      int rv0_snap, winner, k0, k1, exp_g, eg, last_g, bcnt;
      int rd_cyc, wr_cyc, rd_port;
      logic rd_pend, wr_pend;
      logic [7:0] rd_exp, wr_a, wr_d;
      logic pv[2], pwe[2];
      logic [7:0] pa[2], pd[2];

      tbl[0] = '{0, 1'b1, 8'h10, 8'h5A, 8'h00};
      tbl[1] = '{0, 1'b0, 8'h10, 8'h00, 8'h5A};
      tbl[2] = '{1, 1'b1, 8'hFF, 8'hFF, 8'h00};
      tbl[3] = '{1, 1'b0, 8'h00, 8'h00, 8'h3C};
      tbl[4] = '{1, 1'b0, 8'hFF, 8'h00, 8'hFF};
      tbl[5] = '{0, 1'b1, 8'h00, 8'h81, 8'h00};
      tbl[6] = '{0, 1'b0, 8'h00, 8'h00, 8'h81};

      pl_en = 1'b0; pl_addr = 8'h00; pl_dat = 8'h00;
      set_req(0, 0, 0, 0, 0);
      set_req(1, 0, 0, 0, 0);
      n_rst = 1'b1;
      #2 n_rst = 1'b0;
      @(negedge clk);
      chk("rst_ncs", ram_n_cs, 1);
      chk("rst_nrw", ram_n_rw, 0);
      chk("rst_noe", ram_n_oe, 1);
      chk("rst_addr", ram_addr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", {rif.req0_ready, rif.req1_ready}, 0);
      chk("rst_rvalid", {rif.req0_rvalid, rif.req1_rvalid}, 0);
      chk("rst_rdata", {rif.req0_rdata, rif.req1_rdata}, 0);
      @(posedge clk); #1 n_rst = 1'b1;

      // Preload RAM and reference memory identically; 0x00 holds 0x3C
      for (int a = 0; a < 256; a++) begin
         pl_en = 1'b1; pl_addr = 8'(a);
         pl_dat = (a == 0) ? 8'h3C : (8'(a) ^ 8'hA5);
         model_mem[a] = pl_dat;
         @(posedge clk); #1;
      end
      pl_en = 1'b0;

      // Directed table
      rv0_snap = 0;
      for (int i = 0; i < 7; i++) begin
         do_txn(tbl[i]);
         if (i == 1) rv0_snap = rv0;
         if (i == 4) chk("port1_no_rvalid0", rv0, rv0_snap);
      end

      // Reset during RD_ISSUE: everything returns to reset values at once
      set_req(0, 1'b1, 1'b0, 8'h10, 8'h00);
      @(negedge clk);
      @(posedge clk); #1;
      set_req(0, 0, 0, 0, 0);
      @(negedge clk);
      chk("pre_abort_ncs", ram_n_cs, 0);
      rv0_snap = rv0;
      n_rst = 1'b0;
      #1;
      chk("abort_rd_ncs", ram_n_cs, 1);
      chk("abort_rd_nrw", ram_n_rw, 0);
      chk("abort_rd_noe", ram_n_oe, 1);
      chk("abort_rd_addr", ram_addr, 0);
      chk("abort_rd_busy", busy, 0);
      chk("abort_rd_rdata0", rif.req0_rdata, 0);
      chk("abort_rd_rvalid", {rif.req0_rvalid, rif.req1_rvalid}, 0);
      @(posedge clk); @(posedge clk); #1 n_rst = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("abort_rd_no_rvalid", rv0, rv0_snap);

      // Reset during WR: n_cs released before the edge, memory untouched
      set_req(1, 1'b1, 1'b1, 8'h20, 8'h77);
      @(negedge clk);
      @(posedge clk); #1;
      set_req(1, 0, 0, 0, 0);
      @(negedge clk);
      n_rst = 1'b0;
      #1;
      chk("abort_wr_ncs", ram_n_cs, 1);
      @(posedge clk); #1;
      chk("abort_wr_mem", ram_mem[8'h20], model_mem[8'h20]);
      @(posedge clk); #1 n_rst = 1'b1;

      // Both ports continuously valid
      do_reset();
      k0 = 0; k1 = 0;
      set_req(0, 1'b1, 1'b1, 8'h40, 8'h00);
      set_req(1, 1'b1, 1'b1, 8'h50, 8'h80);
      for (int g = 0; g < 6; g++) begin
         winner = -1;
         for (int w = 0; w < 8 && winner < 0; w++) begin
            @(negedge clk);
            chk("arb_one_ready", rif.req0_ready & rif.req1_ready, 0);
            if (rif.req0_ready) winner = 0;
            else if (rif.req1_ready) winner = 1;
            else begin @(posedge clk); #1; end
         end
         if (winner < 0) begin
            fail_now("arb_timeout");
         end else begin
`ifdef RAM_ARBITER_RR_EN
            exp_g = g % 2;
`else
            exp_g = 0;
`endif
            chk("arb_grant", winner, exp_g);
            @(posedge clk); #1;
            if (winner == 0) begin
               model_mem[8'h40 + 8'(k0)] = 8'(k0);
               k0++;
               set_req(0, 1'b1, 1'b1, 8'h40 + 8'(k0), 8'(k0));
            end else begin
               model_mem[8'h50 + 8'(k1)] = 8'h80 + 8'(k1);
               k1++;
               set_req(1, 1'b1, 1'b1, 8'h50 + 8'(k1), 8'h80 + 8'(k1));
            end
         end
      end
      set_req(0, 0, 0, 0, 0);
      set_req(1, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;

      // Randomized mix against a transaction-level model
      do_reset();
      last_g = 1; bcnt = 0;
      rd_pend = 0; wr_pend = 0; rd_cyc = 0; wr_cyc = 0; rd_port = 0;
      rd_exp = 0; wr_a = 0; wr_d = 0;
      pv[0] = 0; pv[1] = 0; pwe[0] = 0; pwe[1] = 0;
      pa[0] = 0; pa[1] = 0; pd[0] = 0; pd[1] = 0;
      for (int c = 0; c < 600; c++) begin
         for (int p = 0; p < 2; p++) begin
            if (!pv[p] && $urandom_range(0, 3) != 0) begin
               pv[p]  = 1'b1;
               pwe[p] = 1'($urandom_range(0, 1));
               pa[p]  = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
               pd[p]  = 8'($urandom);
            end
            set_req(p, pv[p], pwe[p], pa[p], pd[p]);
         end
         @(negedge clk);
         eg = -1;
         if (bcnt == 0) begin
`ifdef RAM_ARBITER_RR_EN
            if (pv[0] && pv[1]) eg = (last_g == 0) ? 1 : 0;
            else if (pv[0]) eg = 0;
            else if (pv[1]) eg = 1;
`else
            if (pv[0]) eg = 0;
            else if (pv[1]) eg = 1;
`endif
         end
         chk("rnd_ready0", rif.req0_ready, eg == 0);
         chk("rnd_ready1", rif.req1_ready, eg == 1);
         chk("rnd_busy", busy, bcnt != 0);
         chk("rnd_rvalid0", rif.req0_rvalid, rd_pend && rd_port == 0 && c == rd_cyc);
         chk("rnd_rvalid1", rif.req1_rvalid, rd_pend && rd_port == 1 && c == rd_cyc);
         if (rd_pend && c == rd_cyc) begin
            chk("rnd_rdata", get_rdata(rd_port), rd_exp);
            rd_pend = 0;
         end
         if (rd_pend && c == rd_cyc - 2) begin
            chk("rnd_rd_issue", {ram_n_cs, ram_n_rw, ram_n_oe}, 3'b001);
         end
         if (rd_pend && c == rd_cyc - 1) begin
            chk("rnd_rd_capture", {ram_n_cs, ram_n_rw, ram_n_oe}, 3'b000);
         end
         chk("rnd_oe_only_reading", !ram_n_oe && (ram_n_cs || ram_n_rw), 0);
         if (wr_pend && c == wr_cyc) begin
            chk("rnd_wr_strobe", {ram_n_cs, ram_n_rw, ram_n_oe}, 3'b011);
            chk("rnd_wr_addr", ram_addr, wr_a);
            chk("rnd_wr_data", ram_data, wr_d);
            wr_pend = 0;
         end else begin
            chk("rnd_no_wr", !ram_n_cs && ram_n_rw, 0);
         end
         if (eg >= 0) begin
            last_g = eg;
            if (pwe[eg]) begin
               model_mem[pa[eg]] = pd[eg];
               wr_pend = 1; wr_cyc = c + 1; wr_a = pa[eg]; wr_d = pd[eg];
               bcnt = 1;
            end else begin
               rd_pend = 1; rd_cyc = c + 3; rd_port = eg; rd_exp = model_mem[pa[eg]];
               bcnt = 2;
            end
            pv[eg] = 1'b0;
         end else if (bcnt > 0) begin
            bcnt--;
         end
         @(posedge clk); #1;
      end
      set_req(0, 0, 0, 0, 0);
      set_req(1, 0, 0, 0, 0);
      repeat (4) @(posedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter and sequencer for the 256x8 single-port synchronous RAM. Two requesters (instruction fetch on port 0, data access on port 1) issue byte read/write requests over a valid/ready handshake. The block grants one request at a time and generates the RAM strobes (`n_cs`, `n_rw`, `n_oe`, address, tri-state data) with the RAM's read/write cycle timing. It returns read data with a one-cycle `rvalid` pulse.

## Interface
- `ADDR_W`, 8, RAM address width
- `DATA_W`, 8, RAM data width
- `clk`  in  1  single clock; all state updates on rising edge
- `n_rst`  in  1  asynchronous, active-low reset
- `req0_valid` / `req1_valid`  in  1  request pending
- `req0_we` / `req1_we`  in  1  1 = write, 0 = read
- `req0_addr` / `req1_addr`  in  ADDR_W  byte address
- `req0_wdata` / `req1_wdata`  in  DATA_W  write data
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle
- `req0_rvalid` / `req1_rvalid`  out  1  one-cycle read-data strobe
- `req0_rdata` / `req1_rdata`  out  DATA_W  read data, held until the next read on that port
- `ram_n_cs`  out  1  RAM chip select, active low
- `ram_n_rw`  out  1  RAM direction: 0 = read, 1 = write
- `ram_n_oe`  out  1  RAM output enable, active low
- `ram_addr`  out  ADDR_W  RAM address
- `ram_data`  inout  DATA_W  RAM data bus
- `busy`  out  1  state != IDLE

## Operation
- States: IDLE, WR, RD_ISSUE, RD_CAPTURE.
- **IDLE**
  - If any `reqN_valid` is high, grant exactly one requester and raise its `reqN_ready` combinationally.
  - On the next edge, latch `we`, `addr` and `wdata`, plus the grant index.
  - Then go to WR if `we` = 1, else go to RD_ISSUE.
- **WR**
  - Drive `ram_n_cs`=0, `ram_n_rw`=1, `ram_n_oe`=1, and drive `ram_data` with the latched data.
  - The RAM writes on the edge. Return to IDLE.
- **RD_ISSUE**
  - Drive `ram_n_cs`=0, `ram_n_rw`=0, `ram_n_oe`=1, `ram_data`=Z.
  - The RAM latches its output register on the edge. Go to RD_CAPTURE.
- **RD_CAPTURE**
  - Drive `ram_n_cs`=0, `ram_n_rw`=0, `ram_n_oe`=0, `ram_data`=Z.
  - On the edge, load `ram_data` into the granted port's `rdata` register and set that port's `rvalid` for one cycle.
  - Return to IDLE.
- **RAM strobes**
  - Decode from the state register and latched request only; no combinational path from the `req*` inputs.
  - `ram_addr` holds the latched address, or 0 in IDLE.
- **Data bus**: the block drives `ram_data` only in WR; Z in all other states. No contention is possible, because the RAM drives only with `n_oe`=0 and `n_rw`=0.
- **Request stability**: the requester holds valid, we, addr and wdata stable until ready. The block never drops an accepted request.
- **Ready**: `reqN_ready` is only ever high in IDLE, and at most one is high per cycle.
- **Reset**: `n_rst` low forces the following immediately, mid-operation included:
  - state IDLE; `ram_n_cs`=1, `ram_n_rw`=0, `ram_n_oe`=1, `ram_addr`=0, `ram_data`=Z;
  - both `ready`=0, both `rvalid`=0, both `rdata`=0, `busy`=0, round-robin pointer = 1.
  - An aborted read produces no `rvalid`. An aborted write has `n_cs` deasserted before the edge, so no write occurs.

## Timing
- Accept cycle T (IDLE, ready=1).
- Write: WR in T+1; memory updated at the end of T+1; next accept no earlier than T+2.
- Read: RD_ISSUE in T+1, RD_CAPTURE in T+2, `rvalid` and `rdata` valid in T+3. The next accept can occur in T+3, overlapping `rvalid`.
- Throughput: one write per 2 cycles, one read per 3 cycles.

## Configuration
- Macro `RAM_ARBITER_RR_EN` selects the arbitration policy.
- **Defined (round-robin)**
  - A 1-bit pointer records the last granted port and updates on every accept.
  - When both ports are valid, the port not granted last wins.
  - After reset the pointer = 1, so port 0 wins the first tie.
- **Undefined (fixed priority)**: port 0 always wins ties; no pointer register.
- With a single valid requester, both policies grant it.

## Structure
- Package `ram_arbiter_pkg` holds:
  - the state enum `arb_state_t` (IDLE, WR, RD_ISSUE, RD_CAPTURE);
  - localparams for the strobe encodings (`RAM_RD`=0, `RAM_WR`=1).
- Sub-module `ram_arbiter_grant` contains the grant logic (fixed or round-robin, pointer included). Inputs: the two valids plus an accept strobe. Output: a one-hot grant.

## Test plan
- Reset mid-read: assert `n_rst` during RD_ISSUE → all outputs at reset values immediately, no `rvalid`, `ram_data` Z.
- Port 0 writes 0x5A to 0x10, then reads 0x10 → `ram_n_cs` low for 1 cycle with `ram_n_rw`=1; on the read, `req0_rvalid` pulses in T+3 with `req0_rdata`=0x5A.
- Port 1 writes 0xFF to address 0xFF (top boundary), then reads address 0x00 after a preloaded 0x3C → `req1_rdata` = 0x3C, then a read of 0xFF returns 0xFF; `req0_rvalid` never asserts.
- Both ports continuously valid, `RAM_ARBITER_RR_EN` defined → grants alternate 0,1,0,1; undefined → port 0 is granted every time and port 1 starves.
- `ram_data` monitor across random read/write mix → the block drives only in WR, the RAM drives only in RD_CAPTURE, never both. `ready` is high only in IDLE, never on both ports at once.
